// File: rtl/alu_pkg.sv
// alu_pkg: funct codes, result-stage state encoding and datapath width shared by the ALU result stage.
package alu_pkg;
    localparam int DATA_W = 32;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    typedef enum logic [1:0] {IDLE, MUL, MUL_PEND} state_e;
endpackage

// File: rtl/hilo_reg.sv
// hilo_reg: 64-bit HI/LO register with load enable, cleared by asynchronous reset.
module hilo_reg
    import alu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_i,
    input  logic [2*W-1:0] d_i,
    output logic [W-1:0]   hi_o,
    output logic [W-1:0]   lo_o
);
    logic [2*W-1:0] hilo_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) hilo_q <= '0;
        else if (load_i) hilo_q <= d_i;
    assign {hi_o, lo_o} = hilo_q;
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registers the shifter/ALU/HI/LO selection by funct code and
// times the MULTU product capture into HI/LO.
module alu_result_stage #(
    parameter int MULT_CYCLES = 32,
    parameter int DATA_W      = alu_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          Signal,
    input  logic [DATA_W-1:0]   aluOut,
    input  logic [DATA_W-1:0]   shifterOut,
    input  logic [2*DATA_W-1:0] prodIn,
    output logic [DATA_W-1:0]   dataOut,
    output logic                dataValid,
    output logic                busy,
    output logic [DATA_W-1:0]   hiOut,
    output logic [DATA_W-1:0]   loOut
);
    import alu_pkg::*;
    localparam int CW = $clog2(MULT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MULT_CYCLES);
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pend_hi_q, pend_hi_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              done, hilo_ld, is_alu, is_mf;
    logic [DATA_W-1:0] fwd;
    assign is_alu = Signal inside {F_AND, F_OR, F_ADD, F_SUB, F_SLT};
    assign is_mf  = Signal inside {F_MFHI, F_MFLO};
    assign done   = state_q != IDLE && cnt_q == CNT_MAX;
    assign fwd    = (state_q == MUL_PEND ? pend_hi_q : Signal == F_MFHI) ? prodIn[2*DATA_W-1:DATA_W] : prodIn[DATA_W-1:0];
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        hilo_ld   = 1'b0;
        if (state_q == IDLE) begin
            if (Signal == F_MULTU) begin
                state_d = MUL;
                cnt_d   = CW'(1);
            end
        end else if (done) begin
            state_d = IDLE;
            cnt_d   = '0;
            hilo_ld = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == MUL && is_mf) begin
                state_d   = MUL_PEND;
                pend_hi_d = Signal == F_MFHI;
            end
        end
        // A read that meets the capture edge gets the fresh product half directly.
        if (state_q == MUL_PEND) begin
            if (done) begin
                data_d  = fwd;
                valid_d = 1'b1;
            end
        end else if (is_alu || Signal == F_SRL) begin
            data_d  = is_alu ? aluOut : shifterOut;
            valid_d = 1'b1;
        end else if (is_mf && (state_q == IDLE || done)) begin
            data_d  = done ? fwd : (Signal == F_MFHI ? hiOut : loOut);
            valid_d = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    hilo_reg #(.W(DATA_W)) u_hilo (
        .clk   (clk),
        .reset (reset),
        .load_i(hilo_ld),
        .d_i   (prodIn),
        .hi_o  (hiOut),
        .lo_o  (loOut)
    );
    assign dataOut   = data_q;
    assign dataValid = valid_q;
    assign busy      = state_q != IDLE;
endmodule
